lcd_byte_tx: RTL



---
 rtl/lcd_byte_tx.sv | 84 ++++++++
 1 files changed

// File: rtl/lcd_byte_tx.sv
// lcd_byte_tx: HD44780 4-bit byte transmitter with E timing and exec wait; LCD_NIBBLE_CMD_EN adds high-nibble-only transfers
module lcd_byte_tx #(
  parameter int CYCLES_PER_US = 50,
  parameter int SETUP_US      = 1,
  parameter int PULSE_US      = 1,
  parameter int HOLD_US       = 1,
  parameter int EXEC_US       = 50,
  parameter int EXEC_LONG_US  = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_rs,
  input  logic [7:0] in_data,
`ifdef LCD_NIBBLE_CMD_EN
  input  logic       in_nibble,
`endif
  output logic       done,
  output logic [2:0] ctrl_lcd,
  output logic [3:0] data_lcd
);
  typedef enum logic [2:0] {IDLE, HI_SETUP, HI_PULSE, HI_HOLD, LO_SETUP, LO_PULSE, LO_HOLD, EXEC} state_t;
  localparam logic [31:0] T_SETUP = 32'(SETUP_US * CYCLES_PER_US);
  localparam logic [31:0] T_PULSE = 32'(PULSE_US * CYCLES_PER_US);
  localparam logic [31:0] T_HOLD  = 32'(HOLD_US * CYCLES_PER_US);
  localparam logic [31:0] T_EXEC  = 32'(EXEC_US * CYCLES_PER_US);
  localparam logic [31:0] T_LONG  = 32'(EXEC_LONG_US * CYCLES_PER_US);
  state_t state, nxt;
  logic [31:0] cnt, dur;
  logic [7:0] data_q, dsel;
  logic rs_q, nib_q, long_q, in_nib, acc, last, rsel, hi, lo;
`ifdef LCD_NIBBLE_CMD_EN
  assign in_nib = in_nibble;
`else
  assign in_nib = 1'b0;
`endif
  assign in_ready = state == IDLE;
  assign acc = in_valid && in_ready;
  assign dsel = acc ? in_data : data_q;
  assign rsel = acc ? in_rs : rs_q;
  assign hi = nxt == HI_SETUP || nxt == HI_PULSE || nxt == HI_HOLD;
  assign lo = nxt == LO_SETUP || nxt == LO_PULSE || nxt == LO_HOLD;
  always_comb begin
    dur = (state == HI_SETUP || state == LO_SETUP) ? T_SETUP :
          (state == HI_PULSE || state == LO_PULSE) ? T_PULSE :
          (state == HI_HOLD  || state == LO_HOLD)  ? T_HOLD  :
          long_q ? T_LONG : T_EXEC;
    last = cnt == dur - 32'd1;
    nxt = state;
    case (state)
      IDLE:     nxt = acc  ? HI_SETUP : IDLE;
      HI_SETUP: nxt = last ? HI_PULSE : HI_SETUP;
      HI_PULSE: nxt = last ? HI_HOLD  : HI_PULSE;
      HI_HOLD:  nxt = last ? (nib_q ? EXEC : LO_SETUP) : HI_HOLD;
      LO_SETUP: nxt = last ? LO_PULSE : LO_SETUP;
      LO_PULSE: nxt = last ? LO_HOLD  : LO_PULSE;
      LO_HOLD:  nxt = last ? EXEC     : LO_HOLD;
      EXEC:     nxt = last ? IDLE     : EXEC;
      default:  nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ctrl_lcd <= 3'b000;
      data_lcd <= 4'h0;
      done     <= 1'b0;
    end else begin
      state    <= nxt;
      cnt      <= (nxt != state || state == IDLE) ? 32'd0 : cnt + 32'd1;
      data_lcd <= hi ? dsel[7:4] : lo ? dsel[3:0] : 4'h0;
      ctrl_lcd <= {(hi || lo) && rsel, 1'b0, nxt == HI_PULSE || nxt == LO_PULSE};
      done     <= state == EXEC && nxt == IDLE;
      if (acc) begin
        rs_q   <= in_rs;
        data_q <= in_data;
        nib_q  <= in_nib;
        long_q <= !in_rs && in_data[7:2] == 6'd0 && !in_nib;
      end
    end
  end
endmodule
